pcs_tx_gearbox: RTL

PCS_TX_GEARBOX -- requirements
Module: pcs_tx_gearbox

---
 rtl/pcs_tx_gearbox.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pcs_tx_gearbox.sv
// 100BASE-X style PCS transmit: MII nibbles -> 4B/5B code groups -> WIDTH-bit PMA slices.
// A 10-bit buffer drains WIDTH bits per clock; a new code group is requested when it runs low.
module pcs_tx_gearbox #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             tx_ce,
    input  logic             tx_en,
    input  logic [3:0]       txd,
    input  logic             tx_er,
    input  logic             link_status,
    output logic [WIDTH-1:0] bits,
    output logic             tx,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] frames,
    output logic [CNT_W-1:0] errors
);
    generate
        if (WIDTH != 1 && WIDTH != 2 && WIDTH != 5) begin : g_bad_width
            $error("pcs_tx_gearbox: WIDTH must be 1, 2 or 5");
        end
    endgenerate

    localparam logic [4:0] C_I = 5'b11111;
    localparam logic [4:0] C_J = 5'b11000;
    localparam logic [4:0] C_K = 5'b10001;
    localparam logic [4:0] C_T = 5'b01101;
    localparam logic [4:0] C_R = 5'b00111;
    localparam logic [4:0] C_H = 5'b00100;
    localparam logic [3:0] W4 = 4'(WIDTH);

    typedef enum logic [1:0] {IDLE, SSD_K, DATA, ESD_R} state_t;

    function automatic logic [4:0] enc4b5b(input logic [3:0] d);
        case (d)
            4'h0: enc4b5b = 5'b11110;
            4'h1: enc4b5b = 5'b01001;
            4'h2: enc4b5b = 5'b10100;
            4'h3: enc4b5b = 5'b10101;
            4'h4: enc4b5b = 5'b01010;
            4'h5: enc4b5b = 5'b01011;
            4'h6: enc4b5b = 5'b01110;
            4'h7: enc4b5b = 5'b01111;
            4'h8: enc4b5b = 5'b10010;
            4'h9: enc4b5b = 5'b10011;
            4'hA: enc4b5b = 5'b10110;
            4'hB: enc4b5b = 5'b10111;
            4'hC: enc4b5b = 5'b11010;
            4'hD: enc4b5b = 5'b11011;
            4'hE: enc4b5b = 5'b11100;
            default: enc4b5b = 5'b11101;
        endcase
    endfunction

    state_t     state, state_nxt;
    logic [9:0] sbuf, shifted, slot_mask, slot_code, buf_nxt;
    logic [3:0] cnt, rem, cnt_nxt;
    logic [4:0] code;
    logic       err_pending, err_nxt, tx_nxt;
    logic       inc_frames, inc_errors;

    // Valid bits sit left-justified in sbuf; bits[WIDTH-1] is the oldest.
    assign bits  = sbuf[9 -: WIDTH];
    assign tx_ce = (cnt < 4'(2 * WIDTH));

    always_comb begin
        state_nxt = state;
        err_nxt   = err_pending;
        tx_nxt    = tx;
        code      = C_I;
        if (!link_status) begin
            state_nxt = IDLE;
            err_nxt   = 1'b0;
            tx_nxt    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_en) begin
                        code      = C_J;
                        tx_nxt    = 1'b1;
                        err_nxt   = tx_er;
                        state_nxt = SSD_K;
                    end
                end
                SSD_K: begin
                    code      = C_K;
                    err_nxt   = err_pending | tx_er;
                    state_nxt = DATA;
                end
                DATA: begin
                    if (!tx_en) begin
                        code      = C_T;
                        tx_nxt    = 1'b0;
                        err_nxt   = 1'b0;
                        state_nxt = ESD_R;
                    end else if (tx_er || err_pending) begin
                        // a pending error from the preamble replaces the first data nibble
                        code    = C_H;
                        err_nxt = 1'b0;
                    end else begin
                        code = enc4b5b(txd);
                    end
                end
                default: begin
                    code      = C_R;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // New group lands right behind the bits still waiting after this clock's shift.
    always_comb begin
        rem       = cnt - W4;
        shifted   = {sbuf[9-WIDTH:0], {WIDTH{1'b1}}};
        slot_mask = 10'b1111100000 >> rem;
        slot_code = {code, 5'b00000} >> rem;
        buf_nxt   = shifted;
        cnt_nxt   = rem;
        if (tx_ce) begin
            buf_nxt = (shifted & ~slot_mask) | slot_code;
            cnt_nxt = rem + 4'd5;
        end
    end

    assign inc_frames = tx_ce && (code == C_J);
    assign inc_errors = tx_ce && (code == C_H);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbuf        <= '1;
            cnt         <= 4'd10;
            state       <= IDLE;
            tx          <= 1'b0;
            err_pending <= 1'b0;
            frames      <= '0;
            errors      <= '0;
        end else begin
            sbuf <= buf_nxt;
            cnt  <= cnt_nxt;
            if (tx_ce) begin
                state       <= state_nxt;
                tx          <= tx_nxt;
                err_pending <= err_nxt;
            end
            if (cnt_clr)
                frames <= '0;
            else if (inc_frames && frames != '1)
                frames <= frames + 1'b1;
            if (cnt_clr)
                errors <= '0;
            else if (inc_errors && errors != '1)
                errors <= errors + 1'b1;
        end
    end
endmodule
